// File: rtl/phys_pkg.sv
// Shared physics types: Q7.25 fixed point, the JOBB body record and the
// pair-scheduler state encoding.
package phys_pkg;

  localparam int FIX_INT  = 7;
  localparam int FIX_FRAC = 25;
  localparam int FIX_W    = FIX_INT + FIX_FRAC;

  typedef logic signed [FIX_W-1:0] fix_t;

  localparam fix_t FIX_ONE = fix_t'(1) <<< FIX_FRAC;

  // Box record: centre and half-extent per axis (x, y, z at index 0..2)
  typedef struct packed {
    fix_t [2:0] center;
    fix_t [2:0] half;
  } jobb_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SEEK,
    ST_FETCH_A,
    ST_LATCH_A,
    ST_FETCH_B,
    ST_LATCH_B,
    ST_EVAL,
    ST_EMIT,
    ST_DONE
  } sched_state_t;

endpackage

// File: rtl/collision_pair_scheduler_if.sv
// Body-table read port plus the (i, j) contact event stream, seen from the
// scheduler (master) and from the table/response side (slave).
interface collision_pair_scheduler_if #(
  parameter int IDX_W = 3
);
  import phys_pkg::*;

  logic [IDX_W-1:0] body_rd_addr;
  jobb_t            body_rd_data;
  logic             pair_valid;
  logic             pair_ready;
  logic [IDX_W-1:0] pair_a;
  logic [IDX_W-1:0] pair_b;

  modport master (
    output body_rd_addr, pair_valid, pair_a, pair_b,
    input  body_rd_data, pair_ready
  );

  modport slave (
    input  body_rd_addr, pair_valid, pair_a, pair_b,
    output body_rd_data, pair_ready
  );

endinterface

// File: rtl/collision_detector.sv
// Combinational box overlap test: boxes touch only when every axis has
// |ca - cb| strictly below ha + hb.
module collision_detector
  import phys_pkg::*;
(
  input  jobb_t obb_a,
  input  jobb_t obb_b,
  output logic  is_collision
);

  logic [2:0] axis_hit;

  // Two guard bits keep the centre difference and extent sum exact
  for (genvar gi = 0; gi < 3; gi++) begin : g_axis
    logic signed [FIX_W+1:0] ca, cb, ha, hb, diff, mag, reach;
    assign ca    = (FIX_W+2)'($signed(obb_a.center[gi]));
    assign cb    = (FIX_W+2)'($signed(obb_b.center[gi]));
    assign ha    = (FIX_W+2)'($signed(obb_a.half[gi]));
    assign hb    = (FIX_W+2)'($signed(obb_b.half[gi]));
    assign diff  = ca - cb;
    assign mag   = (diff < 0) ? -diff : diff;
    assign reach = ha + hb;
    assign axis_hit[gi] = (mag < reach);
  end

  assign is_collision = &axis_hit;

endmodule

// File: rtl/collision_pair_counter.sv
// Pair index walker: owns (i, j), the row-A-loaded flag, the latched
// activity mask, and derives the eligible / exhausted flags.
module collision_pair_counter #(
  parameter int N_BODIES = 8,
  parameter int IDX_W    = $clog2(N_BODIES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init,
  input  logic                advance,
  input  logic                load_a,
  input  logic [N_BODIES-1:0] mask_in,
  output logic [IDX_W-1:0]    idx_i,
  output logic [IDX_W-1:0]    idx_j,
  output logic                a_loaded,
  output logic                eligible,
  output logic                exhausted
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BODIES - 1);

  logic [N_BODIES-1:0] mask_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_reg <= '0;
      idx_i    <= '0;
      idx_j    <= '0;
      a_loaded <= 1'b0;
    end else if (init) begin
      mask_reg <= mask_in;
      idx_i    <= '0;
      idx_j    <= IDX_W'(1);
      a_loaded <= 1'b0;
    end else if (advance) begin
      if (idx_j < LAST_IDX) begin
        idx_j <= idx_j + IDX_W'(1);
      end else begin
        // New row: its A record has to be fetched again
        idx_i    <= idx_i + IDX_W'(1);
        idx_j    <= idx_i + IDX_W'(2);
        a_loaded <= 1'b0;
      end
    end else if (load_a) begin
      a_loaded <= 1'b1;
    end
  end

  assign exhausted = (idx_i == LAST_IDX);
  assign eligible  = !exhausted && mask_reg[idx_i] && mask_reg[idx_j];

endmodule

// File: rtl/collision_pair_scheduler.sv
// Frame sequencer sweeping all body pairs i < j through one detector and
// streaming contacts. Optional contact matrix output: COLLISION_MATRIX_EN.
module collision_pair_scheduler
  import phys_pkg::*;
#(
  parameter int N_BODIES = 8,
  parameter int IDX_W    = $clog2(N_BODIES)
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      start,
  input  logic [N_BODIES-1:0]       active_mask,
  collision_pair_scheduler_if.master bus,
  output logic                      busy,
  output logic                      done,
  output logic [2*IDX_W:0]          contact_count
`ifdef COLLISION_MATRIX_EN
  ,
  output logic [N_BODIES-1:0][N_BODIES-1:0] collision_matrix
`endif
);

  sched_state_t      state;
  logic [IDX_W-1:0]  rd_addr_reg, pair_a_reg, pair_b_reg;
  jobb_t             obb_a, obb_b;
  logic              hit_r, busy_reg, done_reg, run_en;
  logic [2*IDX_W:0]  count_reg;
  logic              is_collision, start_ok;
  logic              ctr_advance, ctr_load_a;
  logic [IDX_W-1:0]  idx_i, idx_j;
  logic              a_loaded, eligible, exhausted;

  // run_en blocks a start that coincides with reset release
  assign start_ok   = start && run_en && (state == ST_IDLE);
  assign ctr_load_a = (state == ST_LATCH_A);

  always_comb begin
    ctr_advance = 1'b0;
    case (state)
      ST_SEEK: ctr_advance = !exhausted && !eligible;
      ST_EVAL: ctr_advance = !is_collision;
      ST_EMIT: ctr_advance = hit_r && bus.pair_ready;
      default: ctr_advance = 1'b0;
    endcase
  end

  collision_pair_counter #(.N_BODIES(N_BODIES), .IDX_W(IDX_W)) u_counter (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .init      (start_ok),
    .advance   (ctr_advance),
    .load_a    (ctr_load_a),
    .mask_in   (active_mask),
    .idx_i     (idx_i),
    .idx_j     (idx_j),
    .a_loaded  (a_loaded),
    .eligible  (eligible),
    .exhausted (exhausted)
  );

  collision_detector u_detector (
    .obb_a        (obb_a),
    .obb_b        (obb_b),
    .is_collision (is_collision)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= ST_IDLE;
      rd_addr_reg <= '0;
      pair_a_reg  <= '0;
      pair_b_reg  <= '0;
      obb_a       <= '0;
      obb_b       <= '0;
      hit_r       <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      run_en      <= 1'b0;
      count_reg   <= '0;
    end else begin
      run_en   <= 1'b1;
      done_reg <= 1'b0;
      case (state)
        ST_IDLE: if (start_ok) begin
          state     <= ST_SEEK;
          busy_reg  <= 1'b1;
          count_reg <= '0;
        end
        ST_SEEK: if (exhausted) begin
          state    <= ST_DONE;
          done_reg <= 1'b1;
        end else if (eligible) begin
          state       <= a_loaded ? ST_FETCH_B : ST_FETCH_A;
          rd_addr_reg <= a_loaded ? idx_j : idx_i;
        end
        ST_FETCH_A: begin
          state       <= ST_LATCH_A;
          rd_addr_reg <= idx_j;
        end
        ST_LATCH_A: begin
          obb_a <= bus.body_rd_data;
          state <= ST_LATCH_B;
        end
        ST_FETCH_B: state <= ST_LATCH_B;
        ST_LATCH_B: begin
          obb_b <= bus.body_rd_data;
          state <= ST_EVAL;
        end
        ST_EVAL: begin
          hit_r <= is_collision;
          if (is_collision) begin
            pair_a_reg <= idx_i;
            pair_b_reg <= idx_j;
            count_reg  <= count_reg + 1'b1;
            state      <= ST_EMIT;
          end else begin
            state <= ST_SEEK;
          end
        end
        ST_EMIT: if (bus.pair_ready) begin
          hit_r <= 1'b0;
          state <= ST_SEEK;
        end
        ST_DONE: begin
          busy_reg <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.body_rd_addr = rd_addr_reg;
  assign bus.pair_valid   = hit_r;
  assign bus.pair_a       = pair_a_reg;
  assign bus.pair_b       = pair_b_reg;
  assign busy             = busy_reg;
  assign done             = done_reg;
  assign contact_count    = count_reg;

`ifdef COLLISION_MATRIX_EN
  logic [N_BODIES-1:0][N_BODIES-1:0] matrix_reg;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      matrix_reg <= '0;
    end else if (start_ok) begin
      matrix_reg <= '0;
    end else if (state == ST_EVAL && is_collision) begin
      matrix_reg[idx_i][idx_j] <= 1'b1;
      matrix_reg[idx_j][idx_i] <= 1'b1;
    end
  end

  assign collision_matrix = matrix_reg;
`endif

endmodule
